// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO.
// Exact count-decoded flags, error pulses, registered or FWFT read.
module sync_fifo_param #(
  parameter int D_LENGTH = 8,
  parameter int A_LENGTH = 4,
  parameter int AE_LEVEL = 2,
  parameter int AF_LEVEL = 14,
  parameter int FWFT     = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [D_LENGTH-1:0] data_in,
  input  logic                rd_en,
  output logic [D_LENGTH-1:0] data_out,
  output logic [A_LENGTH:0]   fill_count,
  output logic                f_empty,
  output logic                f_full,
  output logic                f_almost_empty,
  output logic                f_almost_full,
  output logic                f_half,
  output logic                f_healthy,
  output logic                f_overflow,
  output logic                f_underflow
);

  localparam int DEPTH = 2 ** A_LENGTH;
  localparam int CW    = A_LENGTH + 1;

  localparam logic [A_LENGTH:0] DEPTH_C = CW'(DEPTH);
  localparam logic [A_LENGTH:0] HALF_C  = CW'(DEPTH / 2);
  localparam logic [A_LENGTH:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [A_LENGTH:0] AF_C    = CW'(AF_LEVEL);

  logic [D_LENGTH-1:0] mem [DEPTH];
  logic [A_LENGTH-1:0] wr_ptr;
  logic [A_LENGTH-1:0] rd_ptr;
  logic [A_LENGTH:0]   count;
  logic                wr_acc;
  logic                rd_acc;

  // Requests in a reset cycle are dropped.
  assign wr_acc = wr_en & ~f_full & ~reset;
  assign rd_acc = rd_en & ~f_empty & ~reset;

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  // Error pulses one cycle after a refused request.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_overflow  <= 1'b0;
      f_underflow <= 1'b0;
    end else begin
      f_overflow  <= wr_en & f_full;
      f_underflow <= rd_en & f_empty;
    end
  end

  assign fill_count     = count;
  assign f_empty        = (count == '0);
  assign f_full         = (count == DEPTH_C);
  assign f_almost_empty = (count <= AE_C);
  assign f_almost_full  = (count >= AF_C);
  assign f_half         = (count >= HALF_C);
  assign f_healthy      = (count > AE_C) && (count < AF_C);

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = f_empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
      logic [D_LENGTH-1:0] dout_q;
      // Registered read port, holds between reads.
      always_ff @(posedge clk) begin
        if (reset)       dout_q <= '0;
        else if (rd_acc) dout_q <= mem[rd_ptr];
      end
      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, fully parametrised FIFO: the next-generation buffer for same-clock-domain paths. Width, depth, almost-full/almost-empty thresholds and read mode (registered or first-word-fall-through) are set at elaboration. It provides the same status flag set as the dual-clock FIFO (empty, full, almost-full, almost-empty, half, healthy), plus an occupancy count and overflow/underflow error pulses. No pointer synchronisers are used; flags are exact and carry no synchronisation lag.

## Interface
- D_LENGTH, 8, data width in bits (≥1)
- A_LENGTH, 4, address width; DEPTH = 2**A_LENGTH entries (A_LENGTH ≥ 2)
- AE_LEVEL, 2, f_almost_empty asserted when count ≤ AE_LEVEL (1 ≤ AE_LEVEL < AF_LEVEL)
- AF_LEVEL, 14, f_almost_full asserted when count ≥ AF_LEVEL (AF_LEVEL ≤ DEPTH-1)
- FWFT, 0, 0 = registered read; 1 = first-word-fall-through
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  write request
- data_in  input  D_LENGTH  write data
- rd_en  input  1  read request (FWFT=1: acknowledge/pop of the head word)
- data_out  output  D_LENGTH  read data
- fill_count  output  A_LENGTH+1  number of stored words, 0..DEPTH
- f_empty, f_full, f_almost_empty, f_almost_full, f_half, f_healthy  output  1 each  status flags
- f_overflow  output  1  one-cycle pulse: write refused because FIFO full
- f_underflow  output  1  one-cycle pulse: read refused because FIFO empty

## Operation
- Storage: DEPTH × D_LENGTH array, not reset. Pointers wr_ptr and rd_ptr are A_LENGTH bits wide and wrap naturally from DEPTH-1 to 0. Occupancy is held in a separate A_LENGTH+1-bit count register.
- Acceptance: wr_acc = wr_en & ~f_full; rd_acc = rd_en & ~f_empty. Both are evaluated against the flags before the clock edge.
- wr_acc: mem[wr_ptr] ← data_in; wr_ptr += 1.
- rd_acc: rd_ptr += 1.
- Count update: +1 when only wr_acc; −1 when only rd_acc; unchanged when both are accepted or neither is.
- When full, a write is refused even if rd_en is asserted in the same cycle. The read proceeds, the write does not.
- When empty, a read is refused even if wr_en is asserted in the same cycle. The write proceeds, the read does not. There is no bypass.
- Flags are decoded from the registered count, so they are glitch-free:
  - f_empty = (count == 0)
  - f_full = (count == DEPTH)
  - f_almost_empty = (count ≤ AE_LEVEL)
  - f_almost_full = (count ≥ AF_LEVEL)
  - f_half = (count ≥ DEPTH/2)
  - f_healthy = (AE_LEVEL < count < AF_LEVEL)
- fill_count = count.
- Errors: f_overflow is registered from (wr_en & f_full); f_underflow is registered from (rd_en & f_empty). Each is a pulse in the cycle after the refused request. The pulses are not sticky.
- FWFT=0: data_out is a register loaded with mem[rd_ptr] on rd_acc and holds its value otherwise.
- FWFT=1: data_out = mem[rd_ptr] (combinational array read) while ~f_empty, and is driven 0 while f_empty. rd_acc advances to the next word.
- Reset (reset=1 at an edge), values after that edge:
  - wr_ptr = rd_ptr = count = 0
  - data_out = 0
  - f_empty = 1, f_almost_empty = 1
  - f_full = f_almost_full = f_half = f_healthy = 0
  - f_overflow = f_underflow = 0
- Reset mid-operation discards all contents; any wr_en/rd_en asserted in that cycle is ignored. Memory contents are left stale and never become visible, because the flags show empty.

## Timing
- Write latency: a word written at edge N makes count, fill_count and the flags reflect it after edge N.
  - FWFT=1: data_out shows the word after edge N.
  - FWFT=0: a read may be issued in cycle N+1; data_out is valid after that read's edge.
- Read latency, FWFT=0: rd_acc at edge N → data_out valid after edge N, then held.
- Read latency, FWFT=1: head word is already valid before rd_en; the next word is presented after the rd_acc edge.
- Throughput: one write and one read per cycle are sustained indefinitely whenever 0 < count < DEPTH.
- Error pulses: appear one cycle after the refused request and last exactly one cycle per refused cycle.

## Test plan
- Reset, then 16 writes of 0x01..0x10 (defaults, FWFT=0):
  - f_full=1 and fill_count=16 after the 16th edge
  - f_almost_full rises after the 14th write; f_half rises after the 8th
  - f_healthy high for counts 3..13 only
- Drain 16 reads: data_out = 0x01..0x10 in order, each valid one edge after its rd_acc; f_empty=1 after the last read; one extra rd_en gives a single-cycle f_underflow and data_out holds 0x10.
- Full with wr_en=1 and rd_en=1 together: the read pops the oldest word, the write is refused, f_overflow pulses the next cycle, and fill_count = 15.
- Pointer wrap: at steady count 5, run 40 simultaneous write/read cycles: count stays 5, output sequence is exactly input order across the wrap, and no flag toggles.
- FWFT=1: write 0xA5 into the empty FIFO: data_out=0xA5 and f_empty=0 after the write edge, without any rd_en; rd_en pops it, then data_out=0 and f_empty=1.
- Reset asserted at count 9 together with wr_en=1: the next cycle shows count=0, f_empty=1, f_almost_empty=1, and all other flags, error pulses and data_out at 0.
